// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the 16-bit RISC multi-cycle controller: opcodes,
// funct codes, FSM states, datapath select encodings and the ALU op helper.
// Imported by the controller, its decoder, the datapath and the ALU bench.
package multicycle_ctrl_pkg;

    // Opcodes, ir[15:12]. 1010..1110 are unassigned and trap to ERR.
    localparam logic [3:0] OP_R0   = 4'b0000;
    localparam logic [3:0] OP_R1   = 4'b0001;
    localparam logic [3:0] OP_R2   = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0100;
    localparam logic [3:0] OP_BNEQ = 4'b0101;
    localparam logic [3:0] OP_BGTZ = 4'b0110;
    localparam logic [3:0] OP_J    = 4'b0111;
    localparam logic [3:0] OP_LH   = 4'b1000;
    localparam logic [3:0] OP_SH   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Funct codes, ir[2:0]. The HI/LO pair means multu/mult under OP_R0
    // and divu/div under OP_R1; jr exists only under OP_R1.
    localparam logic [2:0] FN_HILO_U = 3'b010;
    localparam logic [2:0] FN_HILO_S = 3'b011;
    localparam logic [2:0] FN_JR     = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERR
    } state_t;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_ALU    = 2'b11;

    localparam logic [1:0] SRC_B_RT   = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_ZERO = 2'b10;

    localparam logic WB_ALU     = 1'b0;
    localparam logic WB_MEM     = 1'b1;
    localparam logic REG_DST_RD = 1'b0;
    localparam logic REG_DST_RT = 1'b1;
    localparam logic ADDR_PC    = 1'b0;
    localparam logic ADDR_ALU   = 1'b1;

    // Only the register-register groups carry a meaningful funct field.
    function automatic logic [6:0] alu_op_of(input logic [3:0] opcode,
                                             input logic [2:0] funct);
        if (opcode == OP_R0 || opcode == OP_R1 || opcode == OP_R2)
            return {opcode, funct};
        return {opcode, 3'b000};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational instruction classifier for the multi-cycle
// controller. Exactly one class flag is high for any opcode/funct pair.
// Ports:
//   opcode, funct   in   ir[15:12], ir[2:0]
//   is_*            out  instruction class flags
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    output logic       is_rtype,
    output logic       is_hilo,
    output logic       is_jr,
    output logic       is_imm,
    output logic       is_branch,
    output logic       is_jump,
    output logic       is_load,
    output logic       is_store,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        is_rtype   = 1'b0;
        is_hilo    = 1'b0;
        is_jr      = 1'b0;
        is_imm     = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_R0, OP_R1: begin
                if (funct == FN_HILO_U || funct == FN_HILO_S)
                    is_hilo = 1'b1;
                else if (opcode == OP_R1 && funct == FN_JR)
                    is_jr = 1'b1;
                else
                    is_rtype = 1'b1;
            end
            OP_R2:            is_rtype  = 1'b1;
            OP_ADDI, OP_SLTI: is_imm    = 1'b1;
            OP_BNEQ, OP_BGTZ: is_branch = 1'b1;
            OP_J:             is_jump   = 1'b1;
            OP_LH:            is_load   = 1'b1;
            OP_SH:            is_store  = 1'b1;
            OP_HALT:          is_halt   = 1'b1;
            default:          is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC
// core. Drives the memory handshake, datapath selects, the ALU op bus and
// the IR/PC/register-file/HI-LO write strobes.
// Optional build macro: CTRL_MEM_TIMEOUT_EN adds an 8-bit memory wait
// counter that traps to ERR after TIMEOUT_CYCLES stalled cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ir, zero_flag, mem_ready      instruction, ALU zero flag, memory done
//   mem_req, mem_we, mem_addr_sel memory request / store / address select
//   ir_we, pc_we, pc_src_sel      IR capture, PC update and PC source
//   alu_op, alu_src_b_sel         ALU op bus {opcode,funct}, operand B select
//   reg_we, reg_dst_sel, wb_sel   register write strobe, dest and data select
//   hilo_we                       HI/LO write strobe
//   halted, illegal               stopped (HALT/ERR), sticky trap flag
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src_sel,
    output logic [6:0]  alu_op,
    output logic [1:0]  alu_src_b_sel,
    output logic        reg_we,
    output logic        reg_dst_sel,
    output logic        wb_sel,
    output logic        hilo_we,
    output logic        halted,
    output logic        illegal
);

    state_t state_q, state_d;
    // High for every cycle following a sampled rst; silences all outputs so
    // an abandoned FETCH/MEM drops mem_req immediately.
    logic   in_rst_q;

    logic is_rtype, is_hilo, is_jr, is_imm, is_branch;
    logic is_jump, is_load, is_store, is_halt, is_illegal;

    ctrl_decode u_decode (
        .opcode     (ir[15:12]),
        .funct      (ir[2:0]),
        .is_rtype   (is_rtype),
        .is_hilo    (is_hilo),
        .is_jr      (is_jr),
        .is_imm     (is_imm),
        .is_branch  (is_branch),
        .is_jump    (is_jump),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // Register fields are routed by the datapath, not the controller.
    logic unused_ir;
    assign unused_ir = ^ir[11:3];

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            in_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_rst_q <= 1'b0;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    // Any state change clears the count, so it restarts on entry to FETCH/MEM.
    always_ff @(posedge clk) begin
        if (rst || state_d != state_q)
            wait_cnt_q <= 8'd0;
        else if (mem_req && !mem_ready)
            wait_cnt_q <= wait_cnt_q + 8'd1;
    end
`endif

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = ADDR_PC;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src_sel    = PC_SRC_INC;
        alu_op        = 7'd0;
        alu_src_b_sel = SRC_B_RT;
        reg_we        = 1'b0;
        reg_dst_sel   = REG_DST_RD;
        wb_sel        = WB_ALU;
        hilo_we       = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;
        if (!in_rst_q) begin
            alu_op = alu_op_of(ir[15:12], ir[2:0]);
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_halt)         state_d = ST_HALT;
                    else if (is_illegal) state_d = ST_ERR;
                    else                 state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    if (is_hilo) begin
                        hilo_we = 1'b1;
                    end else if (is_jr) begin
                        pc_we      = 1'b1;
                        pc_src_sel = PC_SRC_ALU;
                    end else if (is_rtype) begin
                        state_d = ST_WB;
                    end else if (is_imm) begin
                        alu_src_b_sel = SRC_B_IMM;
                        state_d       = ST_WB;
                    end else if (is_branch) begin
                        // BNEQ compares rs with rt, BGTZ compares rs with zero.
                        alu_src_b_sel = (ir[15:12] == OP_BGTZ) ? SRC_B_ZERO : SRC_B_RT;
                        pc_we         = !zero_flag;
                        pc_src_sel    = PC_SRC_BRANCH;
                    end else if (is_jump) begin
                        pc_we      = 1'b1;
                        pc_src_sel = PC_SRC_JUMP;
                    end else if (is_load || is_store) begin
                        alu_src_b_sel = SRC_B_IMM;
                        state_d       = ST_MEM;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_MEM: begin
                    // Operand B stays on imm6 so the address holds while stalled.
                    mem_req       = 1'b1;
                    mem_addr_sel  = ADDR_ALU;
                    mem_we        = is_store;
                    alu_src_b_sel = SRC_B_IMM;
                    if (mem_ready)
                        state_d = is_store ? ST_FETCH : ST_WB;
                end
                ST_WB: begin
                    reg_we        = 1'b1;
                    wb_sel        = is_load ? WB_MEM : WB_ALU;
                    reg_dst_sel   = (is_imm || is_load) ? REG_DST_RT : REG_DST_RD;
                    alu_src_b_sel = is_imm ? SRC_B_IMM : SRC_B_RT;
                    state_d       = ST_FETCH;
                end
                ST_HALT: halted = 1'b1;
                ST_ERR: begin
                    halted  = 1'b1;
                    illegal = 1'b1;
                end
                default: state_d = ST_ERR;
            endcase
`ifdef CTRL_MEM_TIMEOUT_EN
            if (mem_req && !mem_ready && wait_cnt_q == TIMEOUT_LAST)
                state_d = ST_ERR;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        zero_flag;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src_sel, alu_src_b_sel;
    logic [6:0]  alu_op;
    logic        reg_we, reg_dst_sel, wb_sel, hilo_we, halted, illegal;

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ir(ir), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src_sel(pc_src_sel), .alu_op(alu_op),
        .alu_src_b_sel(alu_src_b_sel), .reg_we(reg_we), .reg_dst_sel(reg_dst_sel),
        .wb_sel(wb_sel), .hilo_we(hilo_we), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] ir;
        logic        zf;
        int          cyc;
        int          regwe_cyc;
        int          hilo_n;
        int          pcwe_n;
        logic [1:0]  pcsrc;
        logic [6:0]  aluop;
        logic [1:0]  srcb;
        logic        regdst;
        logic        wbsel;
        logic        memwe;
    } vec_t;

    vec_t vecs[14];

    // Observations from the most recent instruction run.
    int         obs_cyc, obs_regwe_cyc, obs_regwe_n, obs_hilo_n, obs_pcwe_n, obs_overlap;
    logic [1:0] obs_pcsrc, obs_srcb;
    logic [6:0] obs_aluop;
    logic       obs_regdst, obs_wbsel, obs_memwe, obs_done;

    task automatic tick(input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge
    // where the next FETCH (or a halted state) is visible.
    task automatic run(input logic [15:0] ir_v, input logic zf,
                       input int fetch_wait, input int mem_wait);
        int f_wait, m_wait, ir_we_cyc;
        logic fetch_done;
        ir = ir_v; zero_flag = zf;
        f_wait = 0; m_wait = 0; ir_we_cyc = 0; fetch_done = 1'b0;
        obs_cyc = 0; obs_regwe_cyc = 0; obs_regwe_n = 0; obs_hilo_n = 0;
        obs_pcwe_n = 0; obs_overlap = 0; obs_pcsrc = 2'b00; obs_srcb = 2'b00;
        obs_aluop = 7'd0; obs_regdst = 1'b0; obs_wbsel = 1'b0; obs_memwe = 1'b0;
        obs_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if ((fetch_done && mem_req && !mem_addr_sel) || halted) begin
                obs_done = 1'b1;
                break;
            end
            mem_ready = 1'b0;
            if (mem_req && !mem_addr_sel) begin
                if (f_wait == fetch_wait) mem_ready = 1'b1; else f_wait++;
            end else if (mem_req) begin
                if (m_wait == mem_wait) mem_ready = 1'b1; else m_wait++;
            end
            #1;
            obs_cyc++;
            if (ir_we) begin fetch_done = 1'b1; ir_we_cyc = obs_cyc; end
            if (reg_we) begin
                obs_regwe_n++; obs_regwe_cyc = obs_cyc;
                obs_regdst = reg_dst_sel; obs_wbsel = wb_sel;
            end
            if (hilo_we) obs_hilo_n++;
            if (pc_we && !ir_we) begin obs_pcwe_n++; obs_pcsrc = pc_src_sel; end
            if (fetch_done && obs_cyc == ir_we_cyc + 2) begin
                obs_aluop = alu_op; obs_srcb = alu_src_b_sel;
            end
            if (mem_we) obs_memwe = 1'b1;
            if (int'(reg_we) + int'(hilo_we) + int'(ir_we) > 1) obs_overlap++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        check("run_completed", {31'd0, obs_done}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
    endtask

    initial begin
        //             ir        zf  cyc we  hl pc pcsrc  aluop        srcb  dst  wb   mwe
        vecs[0]  = '{16'h0298, 1'b0, 4, 4, 0, 0, 2'b00, 7'b0000000, 2'b00, 1'b0, 1'b0, 1'b0}; // addu
        vecs[1]  = '{16'h5283, 1'b0, 3, 0, 0, 1, 2'b01, 7'b0101000, 2'b00, 1'b0, 1'b0, 1'b0}; // bneq taken
        vecs[2]  = '{16'h5283, 1'b1, 3, 0, 0, 0, 2'b00, 7'b0101000, 2'b00, 1'b0, 1'b0, 1'b0}; // bneq not taken
        vecs[3]  = '{16'h0012, 1'b0, 3, 0, 1, 0, 2'b00, 7'b0000010, 2'b00, 1'b0, 1'b0, 1'b0}; // multu
        vecs[4]  = '{16'h100A, 1'b0, 3, 0, 1, 0, 2'b00, 7'b0001010, 2'b00, 1'b0, 1'b0, 1'b0}; // divu
        vecs[5]  = '{16'h1007, 1'b0, 3, 0, 0, 1, 2'b11, 7'b0001111, 2'b00, 1'b0, 1'b0, 1'b0}; // jr
        vecs[6]  = '{16'h7123, 1'b0, 3, 0, 0, 1, 2'b10, 7'b0111000, 2'b00, 1'b0, 1'b0, 1'b0}; // j
        vecs[7]  = '{16'h3285, 1'b0, 4, 4, 0, 0, 2'b00, 7'b0011000, 2'b01, 1'b1, 1'b0, 1'b0}; // addi
        vecs[8]  = '{16'h4285, 1'b0, 4, 4, 0, 0, 2'b00, 7'b0100000, 2'b01, 1'b1, 1'b0, 1'b0}; // slti
        vecs[9]  = '{16'h6040, 1'b0, 3, 0, 0, 1, 2'b01, 7'b0110000, 2'b10, 1'b0, 1'b0, 1'b0}; // bgtz taken
        vecs[10] = '{16'h6040, 1'b1, 3, 0, 0, 0, 2'b00, 7'b0110000, 2'b10, 1'b0, 1'b0, 1'b0}; // bgtz not taken
        vecs[11] = '{16'h9283, 1'b0, 4, 0, 0, 0, 2'b00, 7'b1001000, 2'b01, 1'b0, 1'b0, 1'b1}; // sh
        vecs[12] = '{16'h8283, 1'b0, 5, 5, 0, 0, 2'b00, 7'b1000000, 2'b01, 1'b1, 1'b1, 1'b0}; // lh
        vecs[13] = '{16'h229D, 1'b0, 4, 4, 0, 0, 2'b00, 7'b0010101, 2'b00, 1'b0, 1'b0, 1'b0}; // R2 funct 101

        // Reset with mem_ready high: outputs (alu_op included) must stay 0.
        rst = 1'b1; ir = 16'h229D; zero_flag = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs",
              {10'd0, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src_sel, alu_op,
               alu_src_b_sel, reg_we, reg_dst_sel, wb_sel, hilo_we, halted, illegal}, 32'd0);
        rst = 1'b0;
        tick(1'b0);
        check("post_reset_fetch", {30'd0, mem_req, mem_addr_sel}, 32'b10);

        for (int i = 0; i < 14; i++) begin
            run(vecs[i].ir, vecs[i].zf, 0, 0);
            check($sformatf("v%0d_cycles", i), obs_cyc, vecs[i].cyc);
            check($sformatf("v%0d_reg_we_cycle", i), obs_regwe_cyc, vecs[i].regwe_cyc);
            check($sformatf("v%0d_reg_we_count", i), obs_regwe_n, (vecs[i].regwe_cyc != 0) ? 1 : 0);
            check($sformatf("v%0d_hilo_we_count", i), obs_hilo_n, vecs[i].hilo_n);
            check($sformatf("v%0d_pc_we_exec", i), obs_pcwe_n, vecs[i].pcwe_n);
            if (vecs[i].pcwe_n != 0)
                check($sformatf("v%0d_pc_src_sel", i), obs_pcsrc, vecs[i].pcsrc);
            check($sformatf("v%0d_alu_op", i), obs_aluop, vecs[i].aluop);
            check($sformatf("v%0d_src_b_sel", i), obs_srcb, vecs[i].srcb);
            if (vecs[i].regwe_cyc != 0) begin
                check($sformatf("v%0d_reg_dst_sel", i), obs_regdst, vecs[i].regdst);
                check($sformatf("v%0d_wb_sel", i), obs_wbsel, vecs[i].wbsel);
            end
            check($sformatf("v%0d_mem_we", i), obs_memwe, vecs[i].memwe);
            check($sformatf("v%0d_strobe_overlap", i), obs_overlap, 0);
        end

        // One FETCH wait cycle adds one cycle to addu.
        run(16'h0298, 1'b0, 1, 0);
        check("fetch_wait_cycles", obs_cyc, 5);
        check("fetch_wait_reg_we_cycle", obs_regwe_cyc, 5);

        // LH with two MEM wait cycles: write-back at cycle 7 from memory into rt.
        run(16'h8283, 1'b0, 0, 2);
        check("lh_wait_reg_we_cycle", obs_regwe_cyc, 7);
        check("lh_wait_wb_sel", obs_wbsel, 1);
        check("lh_wait_reg_dst_sel", obs_regdst, 1);

        // Reset held for two cycles in the middle of an SH memory stall.
        ir = 16'h9283;
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        #1;
        check("sh_mem_active", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'b111);
        rst = 1'b1;
        tick(1'b0);
        #1;
        check("midmem_reset_mem", {30'd0, mem_req, mem_we}, 32'd0);
        check("midmem_reset_strobes", {27'd0, ir_we, pc_we, reg_we, hilo_we, halted}, 32'd0);
        tick(1'b0);
        rst = 1'b0;
        tick(1'b0);
        check("midmem_reset_fetch", {30'd0, mem_req, mem_addr_sel}, 32'b10);

        // Unassigned opcode traps to ERR; absorbing until reset.
        run(16'hA000, 1'b0, 0, 0);
        check("err_cycles", obs_cyc, 2);
        check("err_flags", {29'd0, halted, illegal, mem_req}, 32'b110);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check("err_absorbing", {29'd0, halted, illegal, ir_we}, 32'b110);
        do_reset();
        check("err_cleared", {29'd0, halted, illegal, mem_req}, 32'b001);

        // HALT stops without the illegal flag.
        run(16'hF000, 1'b0, 0, 0);
        check("halt_flags", {29'd0, halted, illegal, mem_req}, 32'b100);
        tick(1'b1);
        check("halt_absorbing", {30'd0, halted, ir_we}, 32'b10);
        do_reset();

`ifdef CTRL_MEM_TIMEOUT_EN
        // FETCH stalled: four wait cycles then ERR.
        run(16'h0298, 1'b0, 1000, 0);
        check("timeout_cycles", obs_cyc, 4);
        check("timeout_flags", {29'd0, halted, illegal, mem_req}, 32'b110);
        do_reset();
`else
        // No timeout: a 20-cycle FETCH stall simply delays the instruction.
        run(16'h0298, 1'b0, 20, 0);
        check("long_wait_cycles", obs_cyc, 24);
        check("long_wait_not_halted", {31'd0, halted}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
